// File: rtl/noc_in_port.sv
// Router input port: frames NI flits (head/4 data/tail), buffers them in a FIFO and
// forwards each packet wormhole-style to the one-hot output selected by the head flit.
module noc_in_port #(
    parameter int          DEPTH      = 8,
    parameter logic [5:0]  HEADER_TAG = 6'b101111,
    parameter logic [7:0]  TAIL_FLIT  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] flit_in,
    input  logic       flit_in_valid,
    output logic       noc_ready,
    output logic [7:0] out_flit,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic       err_hdr,
    output logic       err_tail,
    output logic [7:0] pkt_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic       last;
        logic [7:0] flit;
    } entry_t;

    typedef enum logic {IDLE, FWD} state_t;

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [2:0]  pos;
    state_t      state;
    logic [1:0]  dest;
    logic [7:0]  flit_hold;

    logic   accept, hdr_ok, push, pop, empty;
    entry_t front;

    assign noc_ready = (count < FULL);
    assign empty     = (count == '0);
    assign front     = mem[rd_ptr[AW-1:0]];
    assign accept    = flit_in_valid && noc_ready;
    assign hdr_ok    = (flit_in[7:2] == HEADER_TAG);
    // A head-position flit with a bad tag is swallowed; framing stays at pos 0.
    assign push      = accept && !(pos == 3'd0 && !hdr_ok);
    assign out_valid = (state == FWD && !empty) ? (4'b0001 << dest) : 4'b0000;
    assign pop       = (state == FWD) && !empty && out_ready[dest];
    // Front entry shows as soon as it lands; otherwise keep the last shown flit.
    assign out_flit  = empty ? flit_hold : front.flit;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{last: (pos == 3'd5), flit: flit_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pos       <= 3'd0;
            err_hdr   <= 1'b0;
            err_tail  <= 1'b0;
            state     <= IDLE;
            dest      <= 2'd0;
            pkt_cnt   <= 8'd0;
            flit_hold <= 8'd0;
        end else begin
            err_hdr  <= accept && (pos == 3'd0) && !hdr_ok;
            err_tail <= accept && (pos == 3'd5) && (flit_in != TAIL_FLIT);

            if (accept) begin
                if (pos == 3'd0)
                    pos <= hdr_ok ? 3'd1 : 3'd0;
                else if (pos == 3'd5)
                    pos <= 3'd0;
                else
                    pos <= pos + 3'd1;
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (!empty) flit_hold <= front.flit;

            case (state)
                IDLE: if (!empty) begin
                    dest  <= front.flit[1:0];
                    state <= FWD;
                end
                FWD: if (pop && front.last) begin
                    state   <= IDLE;
                    pkt_cnt <= pkt_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_noc_in_port.sv
// Directed bench for noc_in_port: a framing model fills a scoreboard queue as flits are
// driven, and a negedge monitor pops and compares every delivered flit.
module tb_noc_in_port;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] flit_in;
    logic       flit_in_valid;
    logic       noc_ready;
    logic [7:0] out_flit;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       err_hdr, err_tail;
    logic [7:0] pkt_cnt;

    noc_in_port #(.DEPTH(8), .HEADER_TAG(6'b101111), .TAIL_FLIT(8'hFF)) dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_in_valid(flit_in_valid),
        .noc_ready(noc_ready), .out_flit(out_flit), .out_valid(out_valid),
        .out_ready(out_ready), .err_hdr(err_hdr), .err_tail(err_tail), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] dest;
        logic [7:0] flit;
        logic       last;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0, n_pass = 0;
    int   hdr_seen = 0, tail_seen = 0, exp_hdr = 0, exp_tail = 0;
    int   tb_pos = 0;
    logic [1:0] tb_dest = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Drive one flit; the reference framer decides what should come out.
    task automatic send(input logic [7:0] f);
        int t = 0;
        @(negedge clk);
        flit_in = f;
        flit_in_valid = 1'b1;
        while (!noc_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("send_timeout", 32'd0, 32'd1);
        if (tb_pos == 0) begin
            if (f[7:2] != 6'b101111) exp_hdr++;
            else begin
                tb_dest = f[1:0];
                sbq.push_back('{dest: tb_dest, flit: f, last: 1'b0});
                tb_pos = 1;
            end
        end else begin
            sbq.push_back('{dest: tb_dest, flit: f, last: (tb_pos == 5)});
            if (tb_pos == 5 && f != 8'hFF) exp_tail++;
            tb_pos = (tb_pos == 5) ? 0 : tb_pos + 1;
        end
        @(posedge clk);
        #1 flit_in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [31:0] d, input logic [7:0] tl);
        logic [31:0] dv;
        dv = d;
        send(h);
        send(dv[31:24]); send(dv[23:16]); send(dv[15:8]); send(dv[7:0]);
        send(tl);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check({tag, "_drain_timeout"}, sbq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (err_hdr)  hdr_seen++;
            if (err_tail) tail_seen++;
            if (out_valid !== 4'b0000) begin
                if (sbq.size() == 0) check("spurious_valid", {28'd0, out_valid}, 32'd0);
                else begin
                    check("out_valid", {28'd0, out_valid}, {28'd0, 4'b0001 << sbq[0].dest});
                    check("out_flit", {24'd0, out_flit}, {24'd0, sbq[0].flit});
                    if (out_ready[sbq[0].dest]) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired: sim did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flit_in = 8'h00; flit_in_valid = 1'b0; out_ready = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_noc_ready", {31'd0, noc_ready}, 32'd1);
        check("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("rst_out_flit", {24'd0, out_flit}, 32'd0);
        check("rst_pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
        check("rst_errs", {30'd0, err_hdr, err_tail}, 32'd0);

        // 1: dest 2, DEADBEEF, head visible the cycle after its push
        out_ready = 4'hF;
        send(8'hBE);
        check("t1_head_latency", {24'd0, out_flit}, 32'hBE);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'hFF);
        drain("t1");
        check("t1_pkt_cnt", {24'd0, pkt_cnt}, 32'd1);
        check("t1_no_err", hdr_seen + tail_seen, 32'd0);

        // 2: bad head dropped, then a dest-1 packet
        send(8'h3C);
        send_pkt(8'hBD, 32'h01020304, 8'hFF);
        drain("t2");
        check("t2_err_hdr", hdr_seen, exp_hdr);
        check("t2_err_hdr_once", hdr_seen, 32'd1);
        check("t2_pkt_cnt", {24'd0, pkt_cnt}, 32'd2);

        // 3: backpressure fills the FIFO, then release
        out_ready = 4'h0;
        send_pkt(8'hBF, 32'h11223344, 8'hFF);
        send(8'hBC); send(8'h55);
        @(negedge clk);
        check("t3_full", {31'd0, noc_ready}, 32'd0);
        check("t3_stalled", {28'd0, out_valid}, 32'b1000);
        out_ready = 4'hF;
        send(8'h66); send(8'h77); send(8'h88); send(8'hFF);
        drain("t3");
        check("t3_pkt_cnt", {24'd0, pkt_cnt}, 32'd4);

        // 4: all-0xFF data are data, not tail
        send_pkt(8'hBF, 32'hFFFFFFFF, 8'hFF);
        drain("t4");
        check("t4_pkt_cnt", {24'd0, pkt_cnt}, 32'd5);
        check("t4_idle", {28'd0, out_valid}, 32'd0);

        // 5: bad tail still forwarded, one err_tail pulse
        send_pkt(8'hBC, 32'hA1B2C3D4, 8'h00);
        drain("t5");
        check("t5_err_tail", tail_seen, 32'd1);
        check("t5_pkt_cnt", {24'd0, pkt_cnt}, 32'd6);

        // 6: reset mid-packet drops the partial packet
        out_ready = 4'h0;
        send(8'hBE); send(8'h12); send(8'h34);
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        tb_pos = 0;
        @(negedge clk);
        rst = 1'b0;
        check("t6_out_valid", {28'd0, out_valid}, 32'd0);
        check("t6_noc_ready", {31'd0, noc_ready}, 32'd1);
        check("t6_pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
        out_ready = 4'hF;
        send_pkt(8'hBC, 32'hCAFEF00D, 8'hFF);
        drain("t6");
        check("t6_pkt_after", {24'd0, pkt_cnt}, 32'd1);
        check("t6_err_total", hdr_seen + tail_seen, exp_hdr + exp_tail);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
